adc_spi_responder: RTL

- Peripheral (responder) end of the MCP3008-style 10-bit ADC SPI link that the top-level ADC sampler drives (AD_CLK/CS/DIN/DOUT).
- Takes per-channel sample values from fabric registers, decodes the start/SGL/D2..D0 command, and shifts back a null bit plus a 10-bit result MSB-first.
- Used as an ADC emulator for Pmod loopback on the Tang Primer 9K, and as a bench model for the sampler/FFT path.

---
 rtl/adc_resp_pkg.sv | 16 +
 rtl/spi_pin_sync.sv | 48 ++++
 rtl/adc_spi_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/adc_resp_pkg.sv
// Shared types and constants for the MCP3008-style ADC SPI responder.
package adc_resp_pkg;

    localparam int CMD_BITS = 4;
    localparam int CH_IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CMD,
        SAMPLE,
        DATA,
        TAIL
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes sclk/cs_n/din into clk and produces edge strobes plus levels.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic din,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_lvl,
    output logic din_lvl
);

    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] din_sr;
    logic                   sclk_prev;
    logic                   cs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr   <= '0;
            cs_sr     <= '1;
            din_sr    <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            cs_sr     <= {cs_sr[SYNC_STAGES-2:0], cs_n};
            din_sr    <= {din_sr[SYNC_STAGES-2:0], din};
            sclk_prev <= sclk_sr[SYNC_STAGES-1];
            cs_prev   <= cs_sr[SYNC_STAGES-1];
        end
    end

    // din shares the sclk latency, so din_lvl is the bit present at the strobe
    assign sclk_rise = sclk_sr[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sr[SYNC_STAGES-1] & sclk_prev;
    assign cs_fall   = ~cs_sr[SYNC_STAGES-1] & cs_prev;
    assign cs_rise   = cs_sr[SYNC_STAGES-1] & ~cs_prev;
    assign cs_lvl    = cs_sr[SYNC_STAGES-1];
    assign din_lvl   = din_sr[SYNC_STAGES-1];

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating an MCP3008-style ADC; ADC_LSB_TRAILER_EN adds the LSB-first echo.
module adc_spi_responder
    import adc_resp_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int RES_BITS    = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sclk,
    input  logic                     cs_n,
    input  logic                     din,
    output logic                     dout,
    output logic                     dout_oe,
    input  logic [N_CH*RES_BITS-1:0] ch_data,
    output logic                     cmd_valid,
    output logic                     cmd_sgl,
    output logic [CH_IDX_W-1:0]      cmd_ch,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int CNT_W = $clog2(RES_BITS + 1);

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_lvl, din_lvl;
    logic s_rise, s_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .din       (din),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .cs_lvl    (cs_lvl),
        .din_lvl   (din_lvl)
    );

    assign s_rise = sclk_rise & ~cs_lvl;
    assign s_fall = sclk_fall & ~cs_lvl;

    function automatic logic [RES_BITS-1:0] pick_ch(input logic [N_CH*RES_BITS-1:0] d,
                                                    input logic [CH_IDX_W-1:0] idx);
        pick_ch = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(idx) == k) pick_ch = d[k*RES_BITS +: RES_BITS];
        end
    endfunction

    function automatic logic [RES_BITS-1:0] clamp_pos(input logic signed [RES_BITS:0] v);
        clamp_pos = v[RES_BITS] ? '0 : v[RES_BITS-1:0];
    endfunction

    state_t                state;
    logic [CMD_BITS-2:0]   cmd_sr;
    logic [1:0]            cmd_cnt;
    logic [RES_BITS-1:0]   res;
    logic [CNT_W-1:0]      bit_idx;
    logic                  sample_seen;

    // cmd_sr holds {SGL, D2, D1} when D0 arrives; {D2,D1,D0} is both the
    // single-ended channel and IN+ of the differential pair
    logic [CH_IDX_W-1:0]     sel_ch, neg_ch;
    logic signed [RES_BITS:0] diff;
    logic [RES_BITS-1:0]     next_res;

    assign sel_ch   = {cmd_sr[CMD_BITS-3:0], din_lvl};
    assign neg_ch   = {cmd_sr[CMD_BITS-3:0], ~din_lvl};
    assign diff     = $signed({1'b0, pick_ch(ch_data, sel_ch)})
                    - $signed({1'b0, pick_ch(ch_data, neg_ch)});
    assign next_res = cmd_sr[CMD_BITS-2] ? pick_ch(ch_data, sel_ch) : clamp_pos(diff);

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dout        <= 1'b0;
            dout_oe     <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_sgl     <= 1'b0;
            cmd_ch      <= '0;
            frame_done  <= 1'b0;
            cmd_sr      <= '0;
            cmd_cnt     <= '0;
            res         <= '0;
            bit_idx     <= '0;
            sample_seen <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (cs_rise) begin
                state   <= IDLE;
                dout    <= 1'b0;
                dout_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) state <= WAIT_START;
                    end
                    WAIT_START: begin
                        if (s_rise && din_lvl) begin
                            state   <= CMD;
                            cmd_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (s_rise) begin
                            cmd_sr <= {cmd_sr[CMD_BITS-3:0], din_lvl};
                            if (cmd_cnt == 2'(CMD_BITS - 1)) begin
                                res         <= next_res;
                                cmd_valid   <= 1'b1;
                                cmd_sgl     <= cmd_sr[CMD_BITS-2];
                                cmd_ch      <= sel_ch;
                                sample_seen <= 1'b0;
                                state       <= SAMPLE;
                            end else begin
                                cmd_cnt <= cmd_cnt + 2'd1;
                            end
                        end
                    end
                    SAMPLE: begin
                        if (s_fall) begin
                            if (!sample_seen) begin
                                sample_seen <= 1'b1;
                            end else begin
                                dout_oe <= 1'b1;
                                dout    <= 1'b0;
                                bit_idx <= CNT_W'(RES_BITS - 1);
                                state   <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (s_fall) begin
                            dout <= res[bit_idx];
                            if (bit_idx == '0) begin
                                state <= TAIL;
`ifdef ADC_LSB_TRAILER_EN
                                bit_idx <= CNT_W'(1);
`else
                                frame_done <= 1'b1;
`endif
                            end else begin
                                bit_idx <= bit_idx - CNT_W'(1);
                            end
                        end
                    end
                    TAIL: begin
                        if (s_fall) begin
`ifdef ADC_LSB_TRAILER_EN
                            // bit_idx == 0 marks the echo as finished
                            if (bit_idx != '0) begin
                                dout <= res[bit_idx];
                                if (bit_idx == CNT_W'(RES_BITS - 1)) begin
                                    bit_idx    <= '0;
                                    frame_done <= 1'b1;
                                end else begin
                                    bit_idx <= bit_idx + CNT_W'(1);
                                end
                            end else begin
                                dout <= 1'b0;
                            end
`else
                            dout <= 1'b0;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
